// File: rtl/rr_arb_mux_pkg.sv
// Shared types for the round-robin 4:1 arbitrating mux.
// Optional packet lock is enabled by defining ARB_MUX_LOCK_EN.
package rr_arb_mux_pkg;

    localparam int unsigned N_CH = 4;

    typedef logic [1:0]      ch_sel_t;
    typedef logic [N_CH-1:0] ch_vec_t;

    // Packet lock state, only used when ARB_MUX_LOCK_EN is defined
    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter over four requesters.
// Owns the last-grant pointer, the optional packet lock (ARB_MUX_LOCK_EN)
// and the combinational grant search.
module rr_arbiter_4
    import rr_arb_mux_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  ch_vec_t req,
    input  logic    advance,
    input  logic    last,
    output ch_vec_t grant,
    output ch_sel_t grant_idx
);

    ch_sel_t last_grant_q, last_grant_d;
    ch_vec_t search_grant;
    ch_sel_t search_idx;
    ch_sel_t probe;
    logic    found;

    // First requester at or after last_grant+1, wrapping around
    always_comb begin
        search_grant = '0;
        search_idx   = '0;
        probe        = '0;
        found        = 1'b0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            probe = last_grant_q + ch_sel_t'(k);
            if (!found && req[probe]) begin
                search_grant[probe] = 1'b1;
                search_idx          = probe;
                found               = 1'b1;
            end
        end
    end

`ifdef ARB_MUX_LOCK_EN
    lock_state_t lock_q, lock_d;
    ch_sel_t     lock_ch_q, lock_ch_d;

    // While locked the grant is pinned to the locked channel, valid or not
    always_comb begin
        grant     = search_grant;
        grant_idx = search_idx;
        if (lock_q == LOCK_HELD) begin
            grant            = '0;
            grant[lock_ch_q] = 1'b1;
            grant_idx        = lock_ch_q;
        end
    end

    // Lock on a non-final beat, release on the final beat
    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (advance) begin
            if (last) begin
                lock_d = LOCK_IDLE;
            end else begin
                lock_d    = LOCK_HELD;
                lock_ch_d = grant_idx;
            end
        end
    end

    // Lock state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q    <= LOCK_IDLE;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    // Grant re-evaluated every cycle
    always_comb begin
        grant     = search_grant;
        grant_idx = search_idx;
    end
`endif

    // Pointer moves to the winner on every transfer
    always_comb begin
        last_grant_d = advance ? grant_idx : last_grant_q;
    end

    // Pointer register; reset value 3 gives channel 0 first priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 2'd3;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin 4:1 arbitrating mux with a single registered output stage.
// Define ARB_MUX_LOCK_EN to hold the grant for a whole packet (in_last).
module rr_arb_mux_4_1
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  ch_vec_t         in_valid,
    input  logic [N_CH*W-1:0] in_data,
    input  ch_vec_t         in_last,
    output ch_vec_t         in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output ch_sel_t         out_sel,
    input  logic            out_ready
);

    ch_vec_t        grant;
    ch_sel_t        grant_idx;
    logic           load;
    logic           xfer;
    logic           sel_last;
    logic [W-1:0]   sel_data;

    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q,  out_data_d;
    ch_sel_t        out_sel_q,   out_sel_d;

    rr_arbiter_4 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (xfer),
        .last      (sel_last),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshake: accept when empty or draining; no acceptance during reset
    always_comb begin
        load     = ~out_valid_q | out_ready;
        in_ready = grant & {N_CH{load & rst_n}};
        xfer     = |(in_valid & in_ready);
        sel_last = |(in_last & grant);
    end

    // AND-OR data select driven by the one-hot grant
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            sel_data = sel_data | (in_data[i*W +: W] & {W{grant[i]}});
        end
    end

    // Output stage next state: load a word, drain to empty, or hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = sel_data;
                out_sel_d  = grant_idx;
            end
        end
    end

    // Output stage register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed self-checking bench for rr_arb_mux_4_1 (W=4).
module tb_rr_arb_mux_4_1;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Channel words: ch0=5, ch1=6, ch2=9, ch3=C
    logic [3:0] ch_word [4];

    rr_arb_mux_4_1 #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_sel"},   32'(out_sel),   32'(s));
        check({tag, "_data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        ch_word[0] = 4'h5;
        ch_word[1] = 4'h6;
        ch_word[2] = 4'h9;
        ch_word[3] = 4'hC;
        in_data    = 16'hC965;
        in_last    = 4'b1111;
        in_valid   = 4'b1111;
        out_ready  = 1'b1;
        rst_n      = 1'b0;

        // Reset held two cycles with all channels valid
        #1;
        check("rst_in_ready_comb", 32'(in_ready), 32'h0);
        tick();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("rst", 1'b0, 2'd0, 4'h0);
        check("rst_in_ready2", 32'(in_ready), 32'h0);

        // Release: channel 0 has first priority, then strict rotation
        rst_n = 1'b1;
        #1;
        check("first_in_ready", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), ch_word[k % 4]);
        end
        check("rr_in_ready_after", 32'(in_ready), 32'b0001);

        // Only channel 2 valid: wins repeatedly, pointer ends at 2
        in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("only2_%0d", k), 1'b1, 2'd2, ch_word[2]);
        end

        // From pointer 2 with channels 0,1 valid: wrap to 0, then 1, then 0
        in_valid = 4'b0011;
        tick();
        check_out("wrap0", 1'b1, 2'd0, ch_word[0]);
        tick();
        check_out("wrap1", 1'b1, 2'd1, ch_word[1]);
        tick();
        check_out("wrap2", 1'b1, 2'd0, ch_word[0]);

        // Backpressure: output held, nothing accepted
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        check("bp_in_ready0", 32'(in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("bp%0d", k), 1'b1, 2'd0, ch_word[0]);
            check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'h0);
        end

        // Drain and refill in the same cycle (pointer 0 -> channel 1)
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'b0010);
        tick();
        check_out("bp_release", 1'b1, 2'd1, ch_word[1]);

        // Bubble: no requests, output empties, sel/data hold
        in_valid = 4'b0000;
        #1;
        check("bubble_in_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("bubble", 1'b0, 2'd1, ch_word[1]);

        // Single request on channel 3 after the bubble
        in_valid = 4'b1000;
        #1;
        check("ch3_in_ready", 32'(in_ready), 32'b1000);
        tick();
        check_out("ch3", 1'b1, 2'd3, ch_word[3]);

        // Reset mid-operation discards the pending word
        in_valid = 4'b1111;
        rst_n    = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("midrst", 1'b0, 2'd0, 4'h0);
        rst_n = 1'b1;
        tick();
        check_out("midrst_first", 1'b1, 2'd0, ch_word[0]);

`ifdef ARB_MUX_LOCK_EN
        // Packet lock: ch1 locks on a non-final beat, ch0/ch2 stay valid
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 4'b0111;
        in_last  = 4'b1101;
        tick();
        check_out("lk_ch0", 1'b1, 2'd0, ch_word[0]);
        tick();
        check_out("lk_b0", 1'b1, 2'd1, ch_word[1]);
        // Gap on the locked channel: grant stays on ch1
        in_valid = 4'b0101;
        #1;
        check("lk_gap_in_ready", 32'(in_ready), 32'b0010);
        tick();
        check("lk_gap_valid", 32'(out_valid), 32'h0);
        in_valid = 4'b0111;
        tick();
        check_out("lk_b1", 1'b1, 2'd1, ch_word[1]);
        in_last = 4'b1111;
        tick();
        check_out("lk_b2", 1'b1, 2'd1, ch_word[1]);
        tick();
        check_out("lk_after", 1'b1, 2'd2, ch_word[2]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/rr_arb_mux_4_1.md
Name: rr_arb_mux_4_1

Overview:
- Upstream selection stage for the 4:1 data mux: arbitrates among four valid/ready input channels using round-robin priority.
- Generates the 2-bit select and registers the chosen word into a single output stage with a valid/ready handshake.
- Sits directly upstream of the downstream consumer. Exports the registered select so that sideband muxes can follow it.

Parameters:
- W, 4, data width per channel.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  4  per-channel valid; bit i belongs to channel i.
- in_data  input  4*W  packed channel data; channel i is in_data[i*W +: W].
- in_last  input  4  per-channel end-of-packet. Used only when ARB_MUX_LOCK_EN is defined; otherwise ignored.
- in_ready  output  4  per-channel ready; combinational.
- out_valid  output  1  registered output valid.
- out_data  output  W  registered selected data.
- out_sel  output  2  registered index of the channel that supplied out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n low at a clock edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last_grant=3, so channel 0 has top priority first.
  - Lock state cleared.
- load = ~out_valid | out_ready. The output register accepts a new word when empty, or when it is being drained in the same cycle.
- Grant search:
  - Combinational, over in_valid.
  - Starts at (last_grant+1) mod 4 and goes upward with wrap-around. The first valid channel wins.
  - No valid channel means no grant.
- in_ready[i] = load & grant[i]. At most one bit is set. in_ready never depends on in_valid[j] for j≠i beyond the grant search.
- Transfer on channel i when in_valid[i] & in_ready[i]. At that clock edge:
  - out_data <= channel i data
  - out_sel <= i
  - out_valid <= 1
  - last_grant <= i
- load=1 with no grant: out_valid <= 0. out_data and out_sel hold their previous values.
- load=0: output register and last_grant hold.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word per cycle when out_ready stays high.
- Fairness: with all four channels continuously valid and out_ready=1, grants go 0,1,2,3,0,... Each channel waits at most 3 transfers.
- Stall rule: while out_valid=1 and out_ready=0, out_data and out_sel are stable and in_ready=0.
- Reset mid-operation: any pending output word is discarded. No input transfer occurs in the reset cycle (in_ready=0 while rst_n=0).

Optional Feature:
- Macro ARB_MUX_LOCK_EN.
- When defined:
  - A transfer with in_last[i]=0 sets lock=1 and locks the grant to channel i.
  - While locked, the grant is channel i only, even if in_valid[i]=0; other channels see in_ready=0.
  - A transfer from the locked channel with in_last=1 clears the lock. last_grant still updates on every transfer.
  - Reset clears the lock.
- When undefined: in_last is ignored, there is no lock register, and the grant is re-evaluated every cycle.

Decomposition:
- Package rr_arb_mux_pkg:
  - N_CH=4
  - typedef logic [1:0] ch_sel_t
  - typedef logic [N_CH-1:0] ch_vec_t
- Sub-module rr_arbiter_4:
  - Owns last_grant, the lock state and the grant search.
  - Inputs: req, advance, last.
  - Output: one-hot grant plus encoded index.
- The top level instantiates it alongside the output register and the data select (AND-OR of one-hot grant with data).

Test Plan:
- Reset: hold rst_n=0 two cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0. After release with in_valid=4'b1111 and out_ready=1 -> first out_sel=0.
- Round-robin: in_data={d,c,b,a} (W=4), in_valid=4'b1111, out_ready=1 for 8 cycles -> out_sel 0,1,2,3,0,1,2,3 and out_data a,b,c,d,a,b,c,d.
- Wrap and skip: last grant 2, in_valid=4'b0011 -> grant 0 next, then 1, then 0. With in_valid=4'b0100 only -> channel 2 wins repeatedly.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles -> in_ready=4'b0000, out_data/out_sel stable. out_ready=1 -> next word loads in the same cycle, no bubble.
- Empty/bubble: in_valid=0 with out_ready=1 -> out_valid drops to 0 after one cycle. in_valid[3]=1 next -> out_valid=1, out_sel=3 one cycle later.
- Lock (ARB_MUX_LOCK_EN):
  - ch1 sends 3 beats with in_last=0,0,1 while ch0/ch2 stay valid -> out_sel 1,1,1, then 2.
  - Mid-packet gap on ch1 (in_valid[1]=0) -> out_valid=0 and no other channel is granted.
